// File: rtl/fetchflare_pref_issue_sched.sv
// Prefetch issue scheduler: several prefetch streams share one memory request port.
// Each stream has a one-entry holding register. A round-robin arbiter picks the next
// stream to issue, and a per-stream outstanding counter limits how many requests each
// stream has in flight. Responses are routed back to the issuing stream by ID.
module fetchflare_pref_issue_sched #(
  parameter int NUM_STREAMS     = 4,
  parameter int ADDR_W          = 40,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = $clog2(NUM_STREAMS),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_STREAMS-1:0]        stream_req_valid,
  input  logic [NUM_STREAMS*ADDR_W-1:0] stream_req_addr,
  output logic [NUM_STREAMS-1:0]        stream_req_ready,
  output logic                          mem_req_valid,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [ID_W-1:0]               mem_req_id,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [ID_W-1:0]               mem_rsp_id,
  output logic [NUM_STREAMS-1:0]        stream_rsp_valid,
  input  logic                          flush,
  output logic                          busy
);

  logic [NUM_STREAMS-1:0]             hold_valid;
  logic [NUM_STREAMS-1:0][ADDR_W-1:0] hold_addr;
  logic [NUM_STREAMS-1:0][CNT_W-1:0]  out_cnt;
  logic [NUM_STREAMS-1:0]             cnt_nz;
  logic [NUM_STREAMS-1:0]             elig;
  logic [ID_W-1:0]                    rr_ptr;
  logic [ID_W-1:0]                    win;
  logic                               win_found;
  logic                               mem_hs;
  logic                               load;

  assign mem_hs = mem_req_valid & mem_req_ready;
  // The output register is refilled when it is empty or draining this cycle; flush
  // suppresses any new load so that nothing held at flush time can slip out.
  assign load   = (~mem_req_valid | mem_req_ready) & win_found & ~flush;

  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_stream
    logic              hold_valid_reg;
    logic [ADDR_W-1:0] hold_addr_reg;
    logic [CNT_W-1:0]  out_cnt_reg;
    logic              pend;
    logic [CNT_W:0]    in_flight;
    logic              inc;
    logic              dec;

    // A request sitting in the output register but not yet accepted already counts
    // against the stream's in-flight budget.
    assign pend      = mem_req_valid && (mem_req_id == ID_W'(gi));
    assign in_flight = {1'b0, out_cnt_reg} + (CNT_W+1)'(pend);
    assign elig[gi]  = hold_valid_reg && (in_flight < (CNT_W+1)'(MAX_OUTSTANDING));

    assign inc = mem_hs && (mem_req_id == ID_W'(gi));
    // A response for a stream with nothing outstanding is ignored by the counter.
    assign dec = mem_rsp_valid && (mem_rsp_id == ID_W'(gi)) && (out_cnt_reg != '0);

    assign stream_req_ready[gi] = ~hold_valid_reg;
    assign hold_valid[gi]       = hold_valid_reg;
    assign hold_addr[gi]        = hold_addr_reg;
    assign out_cnt[gi]          = out_cnt_reg;
    assign cnt_nz[gi]           = (out_cnt_reg != '0);

    // Holding register: capture when empty, release when this stream wins, drop on flush.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        hold_valid_reg <= 1'b0;
        hold_addr_reg  <= '0;
      end else if (flush) begin
        hold_valid_reg <= 1'b0;
      end else if (stream_req_valid[gi] && !hold_valid_reg) begin
        hold_valid_reg <= 1'b1;
        hold_addr_reg  <= stream_req_addr[gi*ADDR_W +: ADDR_W];
      end else if (load && (win == ID_W'(gi))) begin
        hold_valid_reg <= 1'b0;
      end
    end

    // Outstanding counter: up on issue handshake, down on response, both cancel out.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        out_cnt_reg <= '0;
      end else if (inc && !dec) begin
        out_cnt_reg <= out_cnt_reg + CNT_W'(1);
      end else if (dec && !inc) begin
        out_cnt_reg <= out_cnt_reg - CNT_W'(1);
      end
    end
  end

  // Rotating-priority search over eligible streams, starting at rr_ptr.
  always_comb begin
    int idx;
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_STREAMS;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win       = ID_W'(idx);
      end
    end
  end

  // Round-robin pointer moves just past the stream that was granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= (win == ID_W'(NUM_STREAMS - 1)) ? '0 : win + ID_W'(1);
    end
  end

  // Memory request output register; contents are frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_id    <= '0;
    end else if (load) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= hold_addr[win];
      mem_req_id    <= win;
    end else if (mem_hs) begin
      mem_req_valid <= 1'b0;
    end
  end

  // Registered one-hot response pulse towards the owning stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stream_rsp_valid <= '0;
    end else begin
      stream_rsp_valid <= mem_rsp_valid ? (NUM_STREAMS'(1) << mem_rsp_id) : '0;
    end
  end

  assign busy = (|hold_valid) | mem_req_valid | (|cnt_nz);

endmodule

// File: doc/fetchflare_pref_issue_sched.md
Name: fetchflare_pref_issue_sched

Overview:
- Shares one memory request port between NUM_STREAMS independent prefetch streams.
- Each stream gets a one-entry holding register.
- Eligible streams are picked by round-robin, and each stream's in-flight requests are capped by a per-stream outstanding counter.
- Responses are routed back to the issuing stream by ID. The block sits between the per-stream prefetch address generators and the L2/memory request interface.

Parameters:
- NUM_STREAMS, 4, number of prefetch streams (≥2).
- ADDR_W, 40, request address width.
- MAX_OUTSTANDING, 4, per-stream in-flight request limit (≥1).
- ID_W, $clog2(NUM_STREAMS), memory request/response ID width.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stream_req_valid  in  NUM_STREAMS  per-stream request valid.
- stream_req_addr  in  NUM_STREAMS*ADDR_W  per-stream address; stream i occupies bits [i*ADDR_W +: ADDR_W].
- stream_req_ready  out  NUM_STREAMS  per-stream accept.
- mem_req_valid  out  1  memory request valid.
- mem_req_addr  out  ADDR_W  memory request address.
- mem_req_id  out  ID_W  issuing stream index.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  memory response valid; always accepted.
- mem_rsp_id  in  ID_W  stream index of the response.
- stream_rsp_valid  out  NUM_STREAMS  one-hot response pulse to a stream.
- flush  in  1  synchronous discard of held (not yet issued) requests.
- busy  out  1  any held, pending or outstanding request.

Behaviour:
- Reset (reset=0, asynchronous):
  - All hold_valid, mem_req_valid, stream_rsp_valid, outstanding counters and the RR pointer are cleared; the pointer points at stream 0.
  - Consequently stream_req_ready is all 1 and busy is 0.
  - mem_req_addr/id reset to 0.
  - Reset mid-transaction drops everything; no response bookkeeping survives.
- Stream intake:
  - stream_req_ready[i] = ~hold_valid[i] (depends on state only, not on valid).
  - When valid&ready, the address is captured into hold_addr[i] and hold_valid[i] is set on the next edge.
- Eligibility:
  - elig[i] = hold_valid[i] & (out_cnt[i] + pend[i] < MAX_OUTSTANDING).
  - pend[i] = mem_req_valid & (mem_req_id==i), i.e. a request already issued but not yet handshaked counts toward the limit.
- Arbitration:
  - A rotating-priority arbiter over elig, with the highest priority at rr_ptr.
  - On load of winner w, rr_ptr becomes (w+1) mod NUM_STREAMS.
  - rr_ptr is unchanged when there is no load.
- Output register:
  - Loads when (~mem_req_valid | mem_req_ready) and |elig.
  - A load sets mem_req_valid, mem_req_addr=hold_addr[w], mem_req_id=w, and clears hold_valid[w] on the same edge.
  - While mem_req_valid & ~mem_req_ready, addr and id are stable.
  - Handshake with no eligible stream clears mem_req_valid.
  - Back-to-back issue is one request per cycle.
- Latency: a stream request accepted at edge T appears on mem_req at edge T+1 (earliest), assuming no contention.
- Outstanding counters:
  - out_cnt[id] increments on mem_req handshake and decrements on mem_rsp_valid for that id.
  - Simultaneous increment and decrement on the same id leaves the count unchanged.
  - A response to a stream with count 0 is ignored; the counter saturates at 0.
  - The counter never exceeds MAX_OUTSTANDING, guaranteed by the eligibility rule.
- Response routing: stream_rsp_valid[mem_rsp_id] pulses exactly one cycle, registered (one edge after mem_rsp_valid).
- Flush:
  - On an edge with flush=1, all hold_valid are cleared and no new load happens that cycle.
  - Any request already on mem_req stays valid and stable until its handshake; it is never retracted.
  - Outstanding counters and rr_ptr are untouched.
  - A stream request handshaked in the flush cycle is discarded (flush wins).
- busy = |hold_valid | mem_req_valid | (any out_cnt != 0).

Test Plan:
- Reset, then a single request: stream 2 addr 0x1000 with mem_req_ready=1 → mem_req_valid at T+1, addr 0x1000, id 2; out_cnt[2]=1; busy=1 until the response with id 2, then stream_rsp_valid=4'b0100 one cycle later.
- Fairness: all 4 streams continuously valid, ready=1, responses returned immediately → issue order of id is 0,1,2,3,0,1… with no stream skipped.
- Backpressure: mem_req_ready=0 for 5 cycles with stream 1 addr 0xA0 pending → addr and id stay constant; stream_req_ready[1]=0 after its second request is held; on ready=1 exactly one issue occurs.
- Outstanding cap: MAX_OUTSTANDING=4, stream 0 only, no responses → exactly 4 issues, then mem_req_valid=0 while hold_valid[0]=1; one response with id 0 → a 5th issue follows.
- Flush: streams 1 and 3 held, mem_req pending with ready=0, pulse flush → held requests are dropped, the pending mem_req is still issued on ready, busy tracks its response.
- Simultaneous events, part 1: request handshake and response on the same id in one cycle → count unchanged.
- Simultaneous events, part 2: a response to an id with count 0 → count stays 0 and stream_rsp_valid still pulses.
